// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_pkg
//  Purpose  : Shared types and constants for the microwave cook timer.
//  Revision : 1.0  initial release
// ============================================================================
package microwave_pkg;

    typedef enum logic [1:0] {MWT_IDLE, MWT_RUN, MWT_DONE} mwt_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_DIGIT_MAX    = 4'd9;

endpackage
`default_nettype wire

// File: rtl/mwt_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module   : mwt_bcd_digit
//  Purpose  : One BCD digit register. Priority: clear, load, decrement.
//             Decrementing from 0 reloads MAXV and raises bout so the next
//             more significant digit decrements on the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module mwt_bcd_digit
    import microwave_pkg::*;
#(
    parameter bcd_t MAXV = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic dec,
    output bcd_t q,
    output logic bout
);

    bcd_t r_q;

    // Digit register: clear, load or decrement-with-reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? MAXV : r_q - 4'd1;
        end
    end

    assign q    = r_q;
    assign bout = dec && !clr && !ld && (r_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/microwave_cook_timer.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_cook_timer
//  Purpose  : Keypad-programmed MM:SS countdown timer. Counts down while the
//             controller reports heat, raises finish when time runs out and
//             exports start_ok for start-button qualification.
//  Config   : MWT_ADD30_EN enables the +30 s key (key_add30).
//  Revision : 1.0  initial release
// ============================================================================
module microwave_cook_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heat,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       key_add30,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       start_ok,
    output logic       finish
);

    localparam logic [1:0]      c_ST_IDLE  = MWT_IDLE;
    localparam logic [1:0]      c_ST_RUN   = MWT_RUN;
    localparam logic [1:0]      c_ST_DONE  = MWT_DONE;
    localparam int              c_PW       = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [15:0]     c_ONE_SEC  = 16'h0001;

    // Digit index 3..0 = min_tens, min_ones, sec_tens, sec_ones
    bcd_t [3:0]      w_q;
    bcd_t [3:0]      w_ld_val;
    bcd_t [3:0]      w_add_val;
    logic [3:0]      w_dec;
    logic [3:0]      w_bout;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [c_PW-1:0] r_pre;
    logic [c_PW-1:0] w_pre_nx;
    logic            r_finish;
    logic            w_clr;
    logic            w_ld;
    logic            w_tick_dec;
    logic            w_tick;
    logic            w_time_nz;
    logic            w_key_ok;
    logic            w_add_ok;
    logic            w_unused;

    assign w_time_nz = (w_q != '0);
    assign w_key_ok  = key_valid && (key_digit <= BCD_DIGIT_MAX);
    assign w_tick    = (r_state == c_ST_RUN) && heat && (r_pre == c_PRE_LAST);

`ifdef MWT_ADD30_EN
    // +30 s: sec_tens+3 with carry into the minutes, saturating at 99:59.
    always_comb begin
        w_add_val = w_q;
        w_add_ok  = key_add30 && (w_q[1] <= BCD_SEC_TENS_MAX);
        if (w_q[1] < 4'd3) begin
            w_add_val[1] = w_q[1] + 4'd3;
        end else begin
            w_add_val[1] = w_q[1] - 4'd3;
            if (w_q[2] != BCD_DIGIT_MAX) begin
                w_add_val[2] = w_q[2] + 4'd1;
            end else if (w_q[3] != BCD_DIGIT_MAX) begin
                w_add_val[2] = 4'd0;
                w_add_val[3] = w_q[3] + 4'd1;
            end else begin
                w_add_val = {BCD_DIGIT_MAX, BCD_DIGIT_MAX, BCD_SEC_TENS_MAX, BCD_DIGIT_MAX};
            end
        end
    end
    assign w_unused = w_bout[3];
`else
    assign w_add_ok  = 1'b0;
    assign w_add_val = w_q;
    assign w_unused  = ^{key_add30, w_bout[3]};
`endif

    // Key decode, run/pause handling and next-state selection.
    always_comb begin
        w_state_nx = r_state;
        w_pre_nx   = r_pre;
        w_clr      = 1'b0;
        w_ld       = 1'b0;
        w_ld_val   = w_q;
        w_tick_dec = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (key_clear) begin
                    w_clr = 1'b1;
                end else if (w_key_ok) begin
                    w_ld     = 1'b1;
                    w_ld_val = {w_q[2], w_q[1], w_q[0], key_digit};
                end else if (w_add_ok) begin
                    w_ld     = 1'b1;
                    w_ld_val = w_add_val;
                end
                // Entry check looks at the time as it will be after this cycle's key
                if (heat && !w_clr && (w_ld ? (w_ld_val != '0) : w_time_nz)) begin
                    w_state_nx = c_ST_RUN;
                    w_pre_nx   = '0;
                end
            end
            c_ST_RUN: begin
                if (key_clear && !heat) begin
                    w_clr      = 1'b1;
                    w_state_nx = c_ST_IDLE;
                end else begin
                    if (heat) begin
                        w_pre_nx = w_tick ? '0 : r_pre + c_PW'(1);
                    end
                    // An add landing on a tick edge takes precedence over that tick
                    if (w_add_ok) begin
                        w_ld     = 1'b1;
                        w_ld_val = w_add_val;
                    end else if (w_tick) begin
                        w_tick_dec = 1'b1;
                        if (w_q == c_ONE_SEC) begin
                            w_state_nx = c_ST_DONE;
                        end
                    end
                end
            end
            c_ST_DONE: begin
                if (key_clear) begin
                    w_clr      = 1'b1;
                    w_state_nx = c_ST_IDLE;
                end else if (w_key_ok) begin
                    w_ld       = 1'b1;
                    w_ld_val   = {4'd0, 4'd0, 4'd0, key_digit};
                    w_state_nx = c_ST_IDLE;
                end
            end
            default: begin
                w_clr      = 1'b1;
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    assign w_dec = {w_bout[2:0], w_tick_dec};

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam bcd_t c_MAXV = (gi == 1) ? BCD_SEC_TENS_MAX : BCD_DIGIT_MAX;
        mwt_bcd_digit #(
            .MAXV   (c_MAXV)
        ) u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (w_clr),
            .ld     (w_ld),
            .ld_val (w_ld_val[gi]),
            .dec    (w_dec[gi]),
            .q      (w_q[gi]),
            .bout   (w_bout[gi])
        );
    end

    // State, prescaler and finish registers; finish follows DONE entry by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_pre    <= '0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pre    <= w_pre_nx;
            r_finish <= (r_state == c_ST_DONE) && (w_state_nx == c_ST_DONE);
        end
    end

    assign min_tens = w_q[3];
    assign min_ones = w_q[2];
    assign sec_tens = w_q[1];
    assign sec_ones = w_q[0];
    assign start_ok = (r_state == c_ST_IDLE) && w_time_nz;
    assign finish   = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_microwave_cook_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microwave_cook_timer
//  Purpose  : Self-checking bench for microwave_cook_timer (TICK_DIV=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_microwave_cook_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       heat = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_clear = 1'b0;
    logic       key_add30 = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       start_ok, finish;

    int checks = 0;
    int passes = 0;

    microwave_cook_timer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .heat      (heat),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .key_clear (key_clear),
        .key_add30 (key_add30),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .start_ok  (start_ok),
        .finish    (finish)
    );

    always #5 clk = ~clk;

`ifdef MWT_ADD30_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    // Model: minutes and seconds as plain integers, mode 0 idle / 1 run / 2 done
    int m_min, m_sec, m_mode, m_heated;
    bit m_fin;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int disp();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    function automatic int m_disp();
        return ((m_min / 10) << 12) | ((m_min % 10) << 8) | ((m_sec / 10) << 4) | (m_sec % 10);
    endfunction

    task automatic m_add30();
        m_sec = m_sec + 30;
        if (m_sec >= 60) begin
            m_sec = m_sec - 60;
            m_min = m_min + 1;
            if (m_min > 99) begin
                m_min = 99;
                m_sec = 59;
            end
        end
    endtask

    // Behavioural model, evaluated on every clock edge
    always @(posedge clk or posedge rst) begin
        int nmode, n;
        bit tk;
        if (rst) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_heated = 0; m_fin = 0;
        end else begin
            nmode = m_mode;
            if (m_mode == 0) begin
                if (key_clear) begin
                    m_min = 0; m_sec = 0;
                end else if (key_valid && key_digit <= 9) begin
                    n = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
                    m_min = n / 100; m_sec = n % 100;
                end else if (ADD_EN && key_add30 && (m_sec / 10) <= 5) begin
                    m_add30();
                end
                if (heat && !key_clear && (m_min != 0 || m_sec != 0)) begin
                    nmode = 1; m_heated = 0;
                end
            end else if (m_mode == 1) begin
                if (key_clear && !heat) begin
                    m_min = 0; m_sec = 0; nmode = 0;
                end else begin
                    tk = 1'b0;
                    if (heat) begin
                        m_heated++;
                        if (m_heated == TD) begin tk = 1'b1; m_heated = 0; end
                    end
                    if (ADD_EN && key_add30 && (m_sec / 10) <= 5) begin
                        m_add30();
                    end else if (tk) begin
                        if (m_sec > 0) m_sec--;
                        else begin m_sec = 59; m_min--; end
                        if (m_min == 0 && m_sec == 0) nmode = 2;
                    end
                end
            end else begin
                if (key_clear) begin
                    nmode = 0;
                end else if (key_valid && key_digit <= 9) begin
                    m_sec = int'(key_digit); nmode = 0;
                end
            end
            m_fin  = (m_mode == 2) && (nmode == 2);
            m_mode = nmode;
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        check("disp", disp(), m_disp());
        check("start_ok", int'(start_ok), int'(m_mode == 0 && (m_min != 0 || m_sec != 0)));
        check("finish", int'(finish), int'(m_fin));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        cyc(1); key_valid = 1'b1; key_digit = d;
        cyc(1); key_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        cyc(1); key_clear = 1'b1;
        cyc(1); key_clear = 1'b0;
    endtask

    task automatic pulse_add30();
        cyc(1); key_add30 = 1'b1;
        cyc(1); key_add30 = 1'b0;
    endtask

    task automatic set_heat(input logic h);
        cyc(1); heat = h;
    endtask

    initial begin
        cyc(2); rst = 1'b0;
        #2 check("reset_disp", disp(), 'h0000);
        check("reset_start_ok", int'(start_ok), 0);
        check("reset_finish", int'(finish), 0);

        // Entry and clear-wins
        press(1); press(2); press(3); press(4); press(5);
        #2 check("entry_2345", disp(), 'h2345);
        check("entry_start_ok", int'(start_ok), 1);
        cyc(1); key_clear = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
        cyc(1); key_clear = 1'b0; key_valid = 1'b0;
        #2 check("clear_wins", disp(), 'h0000);
        press(4'hA);
        #2 check("bad_digit", disp(), 'h0000);
        press(9); press(9); press(9); press(9); press(8);
        #2 check("entry_drop", disp(), 'h9998);
        pulse_clear();

        // Countdown 01:00
        press(1); press(0); press(0);
        set_heat(1'b1);
        cyc(5); #2 check("count_0059", disp(), 'h0059);
        cyc(4); #2 check("count_0058", disp(), 'h0058);

        // Asynchronous reset mid-run
        cyc(1); #1 rst = 1'b1;
        #1 check("mid_rst_disp", disp(), 'h0000);
        check("mid_rst_finish", int'(finish), 0);
        check("mid_rst_start_ok", int'(start_ok), 0);
        cyc(1); rst = 1'b0; heat = 1'b0;

        // Clear ignored while heating, honoured while paused
        press(5);
        set_heat(1'b1);
        cyc(2);
        pulse_clear();
        #2 check("clear_heat_ignored", disp(), 'h0005);
        set_heat(1'b0);
        pulse_clear();
        #2 check("clear_paused", disp(), 'h0000);

        // 00:90 -> 00:89
        press(9); press(0);
        set_heat(1'b1);
        cyc(5); #2 check("count_0089", disp(), 'h0089);
        set_heat(1'b0);
        pulse_clear();

        // Pause preserves the partial second
        press(2);
        set_heat(1'b1);
        cyc(7); heat = 1'b0;
        cyc(20); heat = 1'b1;
        cyc(2); #2 check("pause_zero", disp(), 'h0000);
        check("pause_fin_low", int'(finish), 0);
        cyc(1); #2 check("pause_fin_high", int'(finish), 1);

        // DONE holds through heat toggling
        set_heat(1'b0);
        set_heat(1'b1);
        cyc(1); #2 check("done_hold_fin", int'(finish), 1);
        check("done_hold_disp", disp(), 'h0000);
        pulse_clear();
        #2 check("done_clear_fin", int'(finish), 0);
        check("done_clear_start_ok", int'(start_ok), 0);

        // DONE left by a digit key
        heat = 1'b0;
        press(1);
        set_heat(1'b1);
        cyc(6); #2 check("done2_fin", int'(finish), 1);
        heat = 1'b0;
        press(7);
        #2 check("done_digit_disp", disp(), 'h0007);
        check("done_digit_fin", int'(finish), 0);
        check("done_digit_start_ok", int'(start_ok), 1);
        pulse_clear();

        // +30 s key
        press(4); press(5);
        pulse_add30();
        #2 check("add30_0045", disp(), ADD_EN ? 'h0115 : 'h0045);
        pulse_clear();
        press(9); press(9); press(4); press(5);
        pulse_add30();
        #2 check("add30_sat", disp(), ADD_EN ? 'h9959 : 'h9945);
        pulse_clear();
        press(9); press(0);
        pulse_add30();
        #2 check("add30_ignored", disp(), 'h0090);

        cyc(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
